// File: rtl/px_grid_renderer.sv
// Frame buffer for the 16x12 colour grid, with a bulk-clear engine and a
// fixed 2-cycle scan-out read path indexed by the VGA pixel position.
module px_grid_renderer #(
    parameter int unsigned AW        = 8,
    parameter int unsigned DW        = 3,
    parameter int unsigned COLS      = 16,
    parameter int unsigned ROWS      = 12,
    parameter int unsigned CELL      = 40,
    parameter logic [DW-1:0] CLR_COLOR = 3'b111
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          px_wr,
    input  logic [AW-1:0] px_addr,
    input  logic [DW-1:0] px_data,
    input  logic          clr_req,
    input  logic [9:0]    vga_x,
    input  logic [9:0]    vga_y,
    input  logic          vga_de,
    output logic [DW-1:0] rgb,
    output logic          rgb_de,
    output logic          busy
);

    localparam int unsigned NCELL = COLS * ROWS;
    localparam int unsigned X_MAX = COLS * CELL;
    localparam int unsigned Y_MAX = ROWS * CELL;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_IDLE  = 1'b1;

    logic [0:0]    state, state_nxt;
    logic [AW-1:0] clr_idx, clr_idx_nxt;

    logic          mem_we_c;
    logic [AW-1:0] mem_waddr_c;
    logic [DW-1:0] mem_wdata_c;

    logic [DW-1:0] mem [NCELL];

    logic [9:0]    col_c, row_c, idx_full_c;
    logic          in_range_c;
    logic [AW-1:0] idx_c;

    logic [AW-1:0] idx_q;
    logic          in_range_q;

    // State register and clear pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_CLEAR;
            clr_idx <= '0;
            busy    <= 1'b1;
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_idx_nxt;
            busy    <= (state_nxt == ST_CLEAR);
        end
    end

    // Next state and single write-port arbitration (clear engine owns it in CLEAR)
    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        mem_we_c    = 1'b0;
        mem_waddr_c = px_addr;
        mem_wdata_c = px_data;
        case (state)
            ST_CLEAR: begin
                mem_we_c    = 1'b1;
                mem_waddr_c = clr_idx;
                mem_wdata_c = CLR_COLOR;
                if (clr_idx == AW'(NCELL - 1)) begin
                    state_nxt   = ST_IDLE;
                    clr_idx_nxt = '0;
                end else begin
                    clr_idx_nxt = clr_idx + AW'(1);
                end
            end
            default: begin
                mem_we_c = px_wr && (px_addr < AW'(NCELL));
                if (clr_req) begin
                    state_nxt   = ST_CLEAR;
                    clr_idx_nxt = '0;
                end
            end
        endcase
    end

    // Grid storage has no reset; the clear engine initialises it
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[mem_waddr_c] <= mem_wdata_c;
        end
    end

    // Pixel-to-cell mapping; out-of-range pixels point at cell 0 to keep the index legal
    always_comb begin
        col_c      = vga_x / 10'(CELL);
        row_c      = vga_y / 10'(CELL);
        idx_full_c = row_c * 10'(COLS) + col_c;
        in_range_c = vga_de && (vga_x < 10'(X_MAX)) && (vga_y < 10'(Y_MAX));
        idx_c      = in_range_c ? AW'(idx_full_c) : '0;
    end

    // Two-stage read pipeline; the memory read is read-first against a same-cycle write
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q      <= '0;
            in_range_q <= 1'b0;
            rgb        <= '0;
            rgb_de     <= 1'b0;
        end else begin
            idx_q      <= idx_c;
            in_range_q <= in_range_c;
            rgb        <= in_range_q ? mem[idx_q] : '0;
            rgb_de     <= in_range_q;
        end
    end

endmodule

// File: doc/px_grid_renderer.md
Name: px_grid_renderer

Overview:
Frame-buffer and scan-out stage directly downstream of the game FSM. Stores the 16x12 grid of 3-bit cell colours written through the FSM's pixel-write port (address, data, write strobe). Maps the VGA timing block's current pixel position to a cell and returns that cell's colour to the VGA output with a fixed 2-cycle latency. Contains its own bulk-clear engine so the grid starts white after reset and can be wiped on request.

Parameters:
AW, 8, cell address width
DW, 3, colour width (1 bit each R, G, B)
COLS, 16, grid columns
ROWS, 12, grid rows
CELL, 40, cell edge in screen pixels (COLS*CELL=640, ROWS*CELL=480)
CLR_COLOR, 3'b111, colour written by the clear engine

Ports:
clk  in  1  system clock (pixel clock domain)
rst  in  1  asynchronous, active-high reset
px_wr  in  1  cell write strobe, one write per cycle while high
px_addr  in  AW  cell index = row*COLS + col
px_data  in  DW  cell colour
clr_req  in  1  request full-grid clear (level or pulse; sampled in IDLE only)
vga_x  in  10  current horizontal pixel from VGA timing
vga_y  in  10  current vertical pixel from VGA timing
vga_de  in  1  active-video flag from VGA timing
rgb  out  DW  pixel colour, 2 cycles after vga_x/vga_y/vga_de
rgb_de  out  1  vga_de delayed 2 cycles and qualified by range check
busy  out  1  high while the clear engine runs

Behaviour:
- Storage: NCELL = COLS*ROWS = 192 entries x DW, one write port, one synchronous read port. Contents are not reset; the clear engine initialises them.
- Async reset: state=CLEAR, clr_idx=0, busy=1, rgb=0, rgb_de=0, pipeline registers=0.
- FSM, 2 states:
  CLEAR: each cycle write CLR_COLOR to clr_idx, clr_idx++. The cycle that writes NCELL-1 moves to IDLE. 192 write cycles in total. busy=1 for all CLEAR cycles and drops in the first IDLE cycle.
  IDLE: busy=0. If px_wr=1 and px_addr<NCELL, write px_data to px_addr. px_addr>=NCELL is ignored, with no wrap and no alias. If clr_req=1, go to CLEAR next cycle with clr_idx=0.
- px_wr during CLEAR is dropped; it is not queued.
- clr_req during CLEAR is ignored; there is no restart.
- px_wr and clr_req together in IDLE: the px write commits this cycle, then CLEAR overwrites it.
- Read pipeline:
  Stage 1 (register): col = vga_x/CELL, row = vga_y/CELL, idx = row*COLS+col. in_range = vga_de & vga_x<640 & vga_y<480. Division may use any implementation that is correct for 0..1023.
  Stage 2 (register): memory read at idx. rgb = in_range_d ? mem[idx] : 0. rgb_de = in_range_d.
  Latency is exactly 2 cycles and holds during CLEAR; reads return whatever is currently stored.
- Read and write of the same cell in the same cycle returns the old data (read-first).
- Reset asserted mid-CLEAR or mid-frame: state restarts at CLEAR, idx 0, and outputs go to 0 immediately (asynchronous).
- Cell boundaries: x=39 maps to col 0, x=40 to col 1, x=639 to col 15. y=479 maps to row 11.

Test Plan:
- Release reset, hold vga_de=0 -> busy=1 for exactly 192 cycles, then 0. A subsequent scan of every cell returns 3'b111.
- In IDLE, write px_addr=17, px_data=3'b010. Drive x=40, y=40, de=1 -> rgb=3'b010 with rgb_de=1 exactly 2 cycles later. x=39, y=40 -> 3'b111.
- Write px_addr=192, data=3'b000 -> no cell changes. Write px_addr=191, data=3'b100 and drive x=639, y=479 -> rgb=3'b100.
- Pulse clr_req in IDLE -> busy rises next cycle. px_wr to addr 5 during CLEAR is dropped. After 192 cycles, cell 5 reads 3'b111.
- vga_de=0, or x=700 with de=1 -> rgb=0 and rgb_de=0 two cycles later.
- Assert rst at clr_idx=100 -> rgb and rgb_de go to 0 immediately. After release, busy lasts a full 192 cycles.
